// File: rtl/fetch_queue.sv
// Instruction fetch stage: sequential imem reads into a DEPTH-entry prefetch FIFO,
// redirect flush, push-button instruction injection. Optional macro FETCH_JPREDECODE_EN.
module fetch_queue #(
    parameter int              XLEN      = 32,
    parameter int              DEPTH     = 4,
    parameter int              NUM_INJ   = 2,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              INJ_FUNC0 = 4
) (
    input  logic               clock,
    input  logic               aclr_n,
    output logic [XLEN-1:0]    imem_addr,
    output logic               imem_en,
    input  logic [XLEN-1:0]    imem_rdata,
    input  logic               redirect,
    input  logic [XLEN-1:0]    redirect_pc,
    input  logic [NUM_INJ-1:0] inj_req,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_ins,
    output logic [XLEN-1:0]    out_pc1,
    output logic [XLEN-1:0]    out_jtgt,
    output logic               out_inj
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [XLEN-1:0] ins;
        logic [XLEN-1:0] pc1;
        logic [XLEN-1:0] jtgt;
        logic            inj;
    } entry_t;

    logic [XLEN-1:0]    pc_q, pc_d;
    logic [XLEN-1:0]    cap_q, cap_d;
    logic               infl_q, infl_d;
    logic [PW-1:0]      rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [NUM_INJ-1:0] inj_prev_q, inj_pend_q, inj_pend_d;
    entry_t             mem_q [DEPTH];

    logic               pop, issue, resp_push, inj_push, push, jump;
    logic [CW:0]        occ_after;
    logic [XLEN-1:0]    resp_pc1, resp_jtgt;
    logic [NUM_INJ-1:0] inj_clr;
    logic [4:0]         inj_func;
    logic [31:0]        inj_ins32;
    entry_t             push_ent;

    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready;
    assign out_ins   = mem_q[rd_q].ins;
    assign out_pc1   = mem_q[rd_q].pc1;
    assign out_jtgt  = mem_q[rd_q].jtgt;
    assign out_inj   = mem_q[rd_q].inj;
    assign imem_addr = pc_q;

    // Entries already owed (queued + in flight) minus the one leaving this cycle.
    assign occ_after = {1'b0, count_q} + (CW+1)'(infl_q) - (CW+1)'(pop);
    assign issue     = aclr_n & ~redirect & ~(|inj_pend_q) & (occ_after < (CW+1)'(DEPTH));
    assign imem_en   = issue;

    assign resp_pc1  = cap_q + XLEN'(1);
    assign resp_jtgt = {resp_pc1[XLEN-1:27], imem_rdata[26:0]};
    assign resp_push = infl_q & ~redirect;

`ifdef FETCH_JPREDECODE_EN
    assign jump = resp_push & (imem_rdata[31:27] == 5'b00001);
`else
    assign jump = 1'b0;
`endif

    // Lowest pending channel wins: scan high to low so the last hit sticks.
    always_comb begin
        inj_clr  = '0;
        inj_func = '0;
        for (int i = NUM_INJ - 1; i >= 0; i--) begin
            if (inj_pend_q[i]) begin
                inj_clr    = '0;
                inj_clr[i] = 1'b1;
                inj_func   = 5'((INJ_FUNC0 + i) % 32);
            end
        end
    end

    assign inj_ins32 = {5'b00000, 5'd1, 5'd1, 5'd0, 5'd1, inj_func, 2'b00};
    assign inj_push  = (|inj_pend_q) & ~infl_q & ~redirect &
                       ((count_q != CW'(DEPTH)) | pop);
    assign push      = resp_push | inj_push;

    always_comb begin
        push_ent = '0;
        if (resp_push) begin
            push_ent.ins  = imem_rdata;
            push_ent.pc1  = resp_pc1;
            push_ent.jtgt = resp_jtgt;
            push_ent.inj  = 1'b0;
        end else begin
            push_ent.ins  = XLEN'(inj_ins32);
            push_ent.pc1  = pc_q;
            push_ent.jtgt = '0;
            push_ent.inj  = 1'b1;
        end
    end

    always_comb begin
        pc_d       = pc_q;
        cap_d      = cap_q;
        infl_d     = issue & ~jump;
        rd_d       = rd_q;
        wr_d       = wr_q;
        count_d    = count_q;
        inj_pend_d = (inj_pend_q & ~(inj_push ? inj_clr : '0)) | (inj_req & ~inj_prev_q);

        if (redirect)   pc_d = redirect_pc;
        else if (jump)  pc_d = resp_jtgt;
        else if (issue) pc_d = pc_q + XLEN'(1);
        if (issue) cap_d = pc_q;

        if (redirect) begin
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
        end else begin
            if (push) wr_d = wr_q + PW'(1);
            if (pop)  rd_d = rd_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            pc_q       <= RESET_PC;
            cap_q      <= '0;
            infl_q     <= 1'b0;
            rd_q       <= '0;
            wr_q       <= '0;
            count_q    <= '0;
            inj_prev_q <= '0;
            inj_pend_q <= '0;
        end else begin
            pc_q       <= pc_d;
            cap_q      <= cap_d;
            infl_q     <= infl_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            count_q    <= count_d;
            inj_prev_q <= inj_req;
            inj_pend_q <= inj_pend_d;
        end
    end

    // Storage is cleared on reset so the head outputs read zero immediately.
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push && !redirect) begin
            mem_q[wr_q] <= push_ent;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: stream, J predecode, backpressure, redirect,
// injection and mid-stream reset, checked with immediate assertions.
module tb_fetch_queue;

    logic        clock = 1'b0;
    logic        aclr_n;
    logic [31:0] imem_addr;
    logic        imem_en;
    logic [31:0] imem_rdata = '0;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [1:0]  inj_req;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_ins;
    logic [31:0] out_pc1;
    logic [31:0] out_jtgt;
    logic        out_inj;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] x;

    localparam logic [31:0] INJ4 = 32'h0042_0090;
    localparam logic [31:0] INJ5 = 32'h0042_0094;

    fetch_queue dut (
        .clock(clock), .aclr_n(aclr_n),
        .imem_addr(imem_addr), .imem_en(imem_en), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc), .inj_req(inj_req),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ins(out_ins), .out_pc1(out_pc1), .out_jtgt(out_jtgt), .out_inj(out_inj)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a == 32'd5) ? 32'h0800_0020 : a + 32'h100;
    endfunction

    always @(posedge clock) if (imem_en) imem_rdata <= memf(imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic head(input string tag, input logic [31:0] pc);
        chk({tag, " valid"}, 32'(out_valid), 32'd1);
        chk({tag, " ins"}, out_ins, pc + 32'h100);
        chk({tag, " pc1"}, out_pc1, pc + 32'd1);
        chk({tag, " inj"}, 32'(out_inj), 32'd0);
    endtask

    initial begin
        aclr_n = 1'b0; redirect = 1'b0; redirect_pc = '0; inj_req = '0; out_ready = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst valid", 32'(out_valid), 32'd0);
        chk("rst imem_en", 32'(imem_en), 32'd0);
        chk("rst ins", out_ins, 32'd0);
        chk("rst pc1", out_pc1, 32'd0);
        chk("rst jtgt", out_jtgt, 32'd0);
        chk("rst inj", 32'(out_inj), 32'd0);
        chk("rst addr", imem_addr, 32'd0);

        // Stream from RESET_PC; first head two cycles after the first issue.
        aclr_n = 1'b1;
        #1;
        chk("first issue en", 32'(imem_en), 32'd1);
        chk("first issue addr", imem_addr, 32'd0);
        @(negedge clock);
        chk("c1 valid", 32'(out_valid), 32'd0);
        @(negedge clock);
        head("c2 head", 32'd0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            head("stream", 32'(k));
        end
        @(negedge clock);
        chk("jhead ins", out_ins, 32'h0800_0020);
        chk("jhead pc1", out_pc1, 32'd6);
        chk("jhead jtgt", out_jtgt, 32'h20);
        @(negedge clock);
`ifdef FETCH_JPREDECODE_EN
        chk("jump bubble", 32'(out_valid), 32'd0);
        @(negedge clock);
        head("jump target", 32'h20);
        x = 32'h20;
`else
        head("after j seq", 32'd6);
        x = 32'd6;
`endif

        // Backpressure: hold the head for 10 cycles, then drain in order.
        out_ready = 1'b0;
        repeat (10) @(negedge clock);
        head("bp held", x);
        chk("bp imem_en", 32'(imem_en), 32'd0);
        out_ready = 1'b1;
        #1;
        chk("bp release en", 32'(imem_en), 32'd1);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clock);
            head("bp drain", x + 32'(k));
        end

        // Redirect with entries queued.
        out_ready = 1'b0;
        repeat (2) @(negedge clock);
        redirect = 1'b1; redirect_pc = 32'h40;
        #1;
        chk("redir imem_en", 32'(imem_en), 32'd0);
        @(negedge clock);
        redirect = 1'b0;
        chk("redir t+1 valid", 32'(out_valid), 32'd0);
        chk("redir t+1 addr", imem_addr, 32'h40);
        @(negedge clock);
        chk("redir t+2 valid", 32'(out_valid), 32'd0);
        @(negedge clock);
        head("redir t+3", 32'h40);
        out_ready = 1'b1;
        @(negedge clock);
        head("redir next", 32'h41);

        // Injection: both channels rise together and stay high.
        inj_req = 2'b11;
        @(negedge clock);
        chk("inj stop en", 32'(imem_en), 32'd0);
        head("inj s1", 32'h42);
        @(negedge clock);
        head("inj s2", 32'h43);
        @(negedge clock);
        chk("inj0 ins", out_ins, INJ4);
        chk("inj0 pc1", out_pc1, 32'h44);
        chk("inj0 jtgt", out_jtgt, 32'd0);
        chk("inj0 flag", 32'(out_inj), 32'd1);
        @(negedge clock);
        chk("inj1 ins", out_ins, INJ5);
        chk("inj1 pc1", out_pc1, 32'h44);
        chk("inj1 flag", 32'(out_inj), 32'd1);
        @(negedge clock);
        chk("inj bubble", 32'(out_valid), 32'd0);
        @(negedge clock);
        head("inj resume", 32'h44);
        @(negedge clock);
        head("inj held lvl", 32'h45);
        @(negedge clock);
        head("inj no reinj", 32'h46);
        inj_req = 2'b00;

        // Reset while the FIFO is full.
        out_ready = 1'b0;
        repeat (6) @(negedge clock);
        chk("pre-rst valid", 32'(out_valid), 32'd1);
        aclr_n = 1'b0;
        #1;
        chk("mid rst valid", 32'(out_valid), 32'd0);
        chk("mid rst ins", out_ins, 32'd0);
        chk("mid rst pc1", out_pc1, 32'd0);
        chk("mid rst jtgt", out_jtgt, 32'd0);
        chk("mid rst en", 32'(imem_en), 32'd0);
        chk("mid rst addr", imem_addr, 32'd0);
        @(negedge clock);
        aclr_n = 1'b1; out_ready = 1'b1;
        #1;
        chk("restart en", 32'(imem_en), 32'd1);
        chk("restart addr", imem_addr, 32'd0);
        repeat (2) @(negedge clock);
        head("restart head", 32'd0);
        @(negedge clock);
        head("restart next", 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch stage with a prefetch queue. It issues sequential reads to instruction memory, optionally pre-decodes direct jumps, and buffers fetched instructions in a DEPTH-entry FIFO. Instructions leave on a valid/ready handshake to decode. Redirects from execute flush the queue, and NUM_INJ push-button channels inject canned instructions ahead of the fetched stream. It sits between the PC/imem and the decode pipeline register.

## Interface
- XLEN, 32: instruction and PC width, ≥ 32.
- DEPTH, 4: queue entries, power of two, 2..16.
- NUM_INJ, 2: injection channels, 1..8.
- RESET_PC, 0: PC loaded on reset.
- INJ_FUNC0, 4: func field of channel 0; channel i uses INJ_FUNC0+i, modulo 32.
- clock  in  1  single clock, all state on rising edge.
- aclr_n  in  1  asynchronous active-low reset.
- imem_addr  out  XLEN  fetch PC, driven combinationally from the PC register.
- imem_en  out  1  read request this cycle.
- imem_rdata  in  XLEN  data for the request issued in the previous cycle.
- redirect  in  1  branch or jal/jr taken; flush.
- redirect_pc  in  XLEN  new PC.
- inj_req  in  NUM_INJ  level inputs from push buttons.
- out_valid  out  1  queue head valid.
- out_ready  in  1  decode accepts the head.
- out_ins  out  XLEN  head instruction.
- out_pc1  out  XLEN  head PC+1.
- out_jtgt  out  XLEN  head jump target, {pc1[31:27], ins[26:0]}.
- out_inj  out  1  head is an injected instruction.

## Operation
- **State:** PC register; FIFO (rd/wr pointers, count 0..DEPTH); inflight bit plus its PC; inj_prev and inj_pend registers, NUM_INJ bits each.
- **Issue.** imem_en=1 when all of the following hold:
  - redirect=0
  - inj_pend==0
  - count+inflight+(pop this cycle ? -1 : 0) < DEPTH
  
  On issue: PC <= PC+1, and inflight <= 1 with the issued PC captured.
- **Response.** If inflight is set and not killed, enqueue {imem_rdata, capPC+1, jtgt, inj=0}.
- **Injection.**
  - Rising edges of inj_req (inj_req & ~inj_prev) set inj_pend bits.
  - While any pending bit is set, issue stops and the PC holds.
  - Once the in-flight response has landed, the lowest set index i is enqueued when the FIFO has room: ins = {5'b00000, 5'd1, 5'd1, 5'd0, 5'd1, INJ_FUNC0+i, 2'b00}, pc1 = PC, jtgt = 0, inj=1.
  - Bit i clears when it is enqueued. One injection per cycle.
- **Redirect** has top priority. In the redirect cycle:
  - The FIFO empties: count=0 and pointers reset.
  - inflight is killed, so the next-cycle response is discarded.
  - PC <= redirect_pc.
  - inj_pend is kept. A pop in the same cycle is still honoured.
- **Simultaneous push and pop** on a full FIFO is legal; count stays unchanged.
- **Width rules:**
  - PC+1 wraps modulo 2^XLEN.
  - jtgt uses pc1 bits [31:27]; for XLEN > 32, bits [XLEN-1:27] come from pc1.

## Timing
- Reset (aclr_n=0, asynchronous) forces:
  - PC=RESET_PC
  - count=0, out_valid=0, inflight=0
  - inj_pend=0, inj_prev=0
  - out_ins, out_pc1 and out_jtgt to 0 (registered head), out_inj=0
  - imem_en=0 while in reset
- First issue occurs in the first cycle after aclr_n rises.
- Fetch latency: issue in cycle t, enqueue at the end of t+1, out_valid=1 in t+2.
- Redirect asserted in cycle t: imem_addr=redirect_pc in t+1, and the instruction appears at the head in t+3.
- Steady-state throughput is 1 instruction per cycle when out_ready=1.
- The head is only updated on a pop or on an enqueue into an empty FIFO. Head outputs stay stable while out_valid=1 and out_ready=0.
- Reset asserted mid-operation discards all state immediately.

## Configuration
- FETCH_JPREDECODE_EN defined:
  - A response with ins[31:27]==5'b00001 is enqueued normally.
  - In the same cycle, PC <= {capPC+1[31:27], ins[26:0]}, and any request issued that cycle is killed.
  - Cost is a 1-cycle bubble.
  - redirect in the same cycle overrides this.
- FETCH_JPREDECODE_EN undefined: J-type instructions flow sequentially and decode must redirect. out_jtgt is computed in both builds.

## Test plan
- **Reset and stream:** RESET_PC=0, imem[n]=n+0x100, out_ready=1. After reset, the head in cycle 2 is ins=0x100, pc1=1, followed by one instruction per cycle.
- **Backpressure:** DEPTH=4, out_ready=0 for 10 cycles. count reaches 4, imem_en=0, no overwrite. Release: instructions 0..N come out in order with none lost.
- **Redirect:** redirect=1 with redirect_pc=0x40 while 3 entries are queued. out_valid=0 on the next two cycles, then ins=imem[0x40] with pc1=0x41.
- **Injection:** pulse inj_req[1] and inj_req[0] in the same cycle with INJ_FUNC0=4. Next heads are func=4 then func=5, both with out_inj=1, followed by the sequential stream resuming at the held PC. A held level must not re-inject.
- **J predecode:** imem[5]=0x08000020, macro defined. Head order is 4, 5, 0x20, and imem[6] never reaches the head. With the macro undefined, 6 follows 5.
- **Reset mid-stream:** aclr_n low for 1 cycle while the FIFO is full. Outputs clear immediately, and the stream restarts at RESET_PC.
